nmr_bstrm_multich_dpath: RTL

Multi-channel successor to the single-output bitstream arbitrary datapath. It executes a stream of commands (HOLD a level vector for N cycles, stream a PATTERN of parallel frames, or END) on NCH parallel outputs. A one-entry prefetch buffer with a valid/ready handshake gives gapless back-to-back segments. The block sits between the sequence SRAM controller and the NMR TX/RX gating pins.

---
 rtl/nmr_bstrm_pkg.sv | 37 +++
 rtl/nmr_bstrm_multich_dpath_cmd_buf.sv | 60 ++++++
 rtl/nmr_bstrm_multich_dpath.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/nmr_bstrm_pkg.sv
// nmr_bstrm_pkg
// Shared types and constants for the multi-channel bitstream datapath:
//   op_e     - command opcode carried on the command bus
//   state_e  - sequencer state (IDLE / ARM / RUN)
//   FRAMES   - PATTERN frames per command for the default geometry
//   frames_of()  - frames per PATTERN for an arbitrary geometry
//   is_data_op() - true for opcodes that produce output (HOLD, PATTERN)
package nmr_bstrm_pkg;

  typedef enum logic [1:0] {
    OP_END     = 2'b00,
    OP_HOLD    = 2'b01,
    OP_PATTERN = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF = 120;
  localparam int NCH_DEF        = 4;
  localparam int CNT_W_DEF      = 32;
  localparam int FRAMES         = DATA_WIDTH_DEF / NCH_DEF;

  function automatic int frames_of(input int dw, input int nch);
    return dw / nch;
  endfunction

  // Reserved opcode behaves like END, so only HOLD and PATTERN drive output.
  function automatic logic is_data_op(input op_e op);
    return (op == OP_HOLD) || (op == OP_PATTERN);
  endfunction

endpackage

// File: rtl/nmr_bstrm_multich_dpath_cmd_buf.sv
// nmr_bstrm_cmd_buf
// One-entry prefetch register for the command stream.
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_fill                - load i_op/i_level/i_data and mark valid
//   i_consume             - current entry taken by the sequencer
//   i_flush               - drop the entry (wins over fill and consume)
//   o_valid/o_op/o_level/o_data - stored entry
// Consume and fill in the same cycle leaves the entry valid with new contents,
// which is what gives gapless back-to-back segments.
module nmr_bstrm_cmd_buf
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NCH        = NCH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fill,
  input  logic                  i_consume,
  input  logic                  i_flush,
  input  logic [1:0]            i_op,
  input  logic [NCH-1:0]        i_level,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [1:0]            o_op,
  output logic [NCH-1:0]        o_level,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  op_e                   r_op;
  logic [NCH-1:0]        r_level;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_op    <= OP_END;
      r_level <= '0;
      r_data  <= '0;
    end else begin
      if (i_flush)        r_valid <= 1'b0;
      else if (i_fill)    r_valid <= 1'b1;
      else if (i_consume) r_valid <= 1'b0;

      // Payload may be overwritten while flushing; it is never used invalid.
      if (i_fill) begin
        r_op    <= op_e'(i_op);
        r_level <= i_level;
        r_data  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_level = r_level;
  assign o_data  = r_data;

endmodule

// File: rtl/nmr_bstrm_multich_dpath.sv
// nmr_bstrm_multich_dpath
// Executes a stream of HOLD / PATTERN / END commands on NCH registered outputs,
// with a one-entry prefetch buffer so consecutive segments run without gaps.
//   i_clk, i_rst      - clock, asynchronous active-high reset
//   i_start           - arm pulse, honoured in IDLE only
//   i_abort           - synchronous abort, highest priority
//   i_cmd_valid/o_cmd_rdy - command handshake
//   i_cmd_op/i_cmd_level/i_cmd_data - command payload
//   o_out             - channel outputs
//   o_busy / o_done   - running / idle
//   o_underrun        - sticky: a segment ended with no command buffered
//   o_seg_strobe      - high on the first output cycle of each segment
module nmr_bstrm_multich_dpath
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NCH        = NCH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_rdy,
  input  logic [1:0]            i_cmd_op,
  input  logic [NCH-1:0]        i_cmd_level,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic [NCH-1:0]        o_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_underrun,
  output logic                  o_seg_strobe
);

  localparam int FRAMES_L = frames_of(DATA_WIDTH, NCH);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_L - 1);

  if (DATA_WIDTH % NCH != 0) begin : g_bad_nch
    $error("DATA_WIDTH must be a multiple of NCH");
  end
  if (CNT_W > DATA_WIDTH) begin : g_bad_cnt_w
    $error("CNT_W must not exceed DATA_WIDTH");
  end

  state_e                r_state;
  state_e                w_state_next;
  logic [NCH-1:0]        r_out;
  logic                  r_seg_strobe;
  logic                  r_underrun;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_pat;
  logic                  r_is_pat;

  logic                  w_buf_valid;
  logic [1:0]            w_buf_op;
  logic [NCH-1:0]        w_buf_level;
  logic [DATA_WIDTH-1:0] w_buf_data;
  op_e                   w_buf_op_e;
  logic [CNT_W-1:0]      w_len;

  logic w_seg_end, w_take, w_load, w_load_data, w_load_end;
  logic w_underrun_evt, w_flush, w_fill, w_start_ok, w_cmd_rdy;

  assign w_buf_op_e = op_e'(w_buf_op);
  assign w_len      = w_buf_data[CNT_W-1:0];

  // Counter reaching zero in RUN marks the last output cycle of a segment.
  assign w_seg_end      = (r_state == ST_RUN) && (r_cnt == '0);
  // w_take ignores abort so that the ready path does not depend on i_abort.
  assign w_take         = w_buf_valid && ((r_state == ST_ARM) || w_seg_end);
  assign w_load         = w_take && !i_abort;
  assign w_load_data    = w_load && is_data_op(w_buf_op_e);
  assign w_load_end     = w_load && !is_data_op(w_buf_op_e);
  assign w_underrun_evt = w_seg_end && !w_buf_valid && !i_abort;
  // Any return to IDLE drops whatever was accepted on that same edge.
  assign w_flush        = i_abort || w_load_end || w_underrun_evt;
  assign w_fill         = i_cmd_valid && w_cmd_rdy;
  assign w_start_ok     = (r_state == ST_IDLE) && i_start && !i_abort;

  nmr_bstrm_cmd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NCH        (NCH)
  ) u_cmd_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_fill    (w_fill),
    .i_consume (w_take),
    .i_flush   (w_flush),
    .i_op      (i_cmd_op),
    .i_level   (i_cmd_level),
    .i_data    (i_cmd_data),
    .o_valid   (w_buf_valid),
    .o_op      (w_buf_op),
    .o_level   (w_buf_level),
    .o_data    (w_buf_data)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_state_next = ST_ARM;
        ST_ARM: begin
          if (w_load_data)     w_state_next = ST_RUN;
          else if (w_load_end) w_state_next = ST_IDLE;
        end
        ST_RUN: if (w_load_end || w_underrun_evt) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_busy    = (r_state != ST_IDLE);
    o_done    = (r_state == ST_IDLE);
    w_cmd_rdy = (r_state != ST_IDLE) && (!w_buf_valid || w_take);
  end

  assign o_cmd_rdy = w_cmd_rdy;

  // Segment datapath: OUT, strobe, frame shifter and the down-counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out        <= '0;
      r_seg_strobe <= 1'b0;
      r_underrun   <= 1'b0;
      r_cnt        <= '0;
      r_pat        <= '0;
      r_is_pat     <= 1'b0;
    end else begin
      r_seg_strobe <= w_load_data;

      if (w_start_ok)          r_underrun <= 1'b0;
      else if (w_underrun_evt) r_underrun <= 1'b1;

      if (i_abort || w_load_end || w_underrun_evt) begin
        r_out <= '0;
        r_cnt <= '0;
      end else if (w_load_data) begin
        if (w_buf_op_e == OP_PATTERN) begin
          r_out    <= w_buf_data[DATA_WIDTH-1 -: NCH];
          r_pat    <= w_buf_data << NCH;
          r_cnt    <= LAST_FRAME;
          r_is_pat <= 1'b1;
        end else begin
          // A zero length still occupies one cycle.
          r_out    <= w_buf_level;
          r_cnt    <= (w_len == '0) ? '0 : (w_len - CNT_W'(1));
          r_is_pat <= 1'b0;
        end
      end else if (r_state == ST_RUN) begin
        // Mid-segment: counter is non-zero here, segment end handled above.
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_is_pat) begin
          r_out <= r_pat[DATA_WIDTH-1 -: NCH];
          r_pat <= r_pat << NCH;
        end
      end
    end
  end

  assign o_out        = r_out;
  assign o_seg_strobe = r_seg_strobe;
  assign o_underrun   = r_underrun;

endmodule
